// File: rtl/pcie_us_axis_rc_cpl_parse.sv
// Splits UltraScale RC completion frames into a registered header interface and a payload
// stream realigned so payload dword 0 sits in tdata[31:0]; payload goes through a 2-entry skid.
module pcie_us_axis_rc_cpl_parse #(
    parameter int AXIS_PCIE_DATA_WIDTH    = 256,
    parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
    parameter int AXIS_PCIE_RC_USER_WIDTH = AXIS_PCIE_DATA_WIDTH < 512 ? 75 : 161
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_rc_tdata,
    input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_rc_tkeep,
    input  logic                               s_axis_rc_tvalid,
    output logic                               s_axis_rc_tready,
    input  logic                               s_axis_rc_tlast,
    input  logic [AXIS_PCIE_RC_USER_WIDTH-1:0] s_axis_rc_tuser,

    output logic                               m_axis_hdr_valid,
    input  logic                               m_axis_hdr_ready,
    output logic [11:0]                        m_axis_hdr_lower_addr,
    output logic [3:0]                         m_axis_hdr_error_code,
    output logic [12:0]                        m_axis_hdr_byte_count,
    output logic                               m_axis_hdr_request_completed,
    output logic [10:0]                        m_axis_hdr_dword_count,
    output logic [2:0]                         m_axis_hdr_status,
    output logic                               m_axis_hdr_poisoned,
    output logic [15:0]                        m_axis_hdr_requester_id,
    output logic [7:0]                         m_axis_hdr_tag,
    output logic [15:0]                        m_axis_hdr_completer_id,

    output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_data_tdata,
    output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_data_tkeep,
    output logic                               m_axis_data_tvalid,
    input  logic                               m_axis_data_tready,
    output logic                               m_axis_data_tlast,

    output logic                               stat_error
);
    localparam int DW  = AXIS_PCIE_DATA_WIDTH;
    localparam int KW  = AXIS_PCIE_KEEP_WIDTH;
    localparam int RDW = DW - 96;
    localparam int RKW = KW - 3;

    if (!(DW == 128 || DW == 256 || DW == 512)) begin : g_bad_width
        $error("pcie_us_axis_rc_cpl_parse: AXIS_PCIE_DATA_WIDTH must be 128, 256 or 512");
    end
    if (KW * 32 != DW) begin : g_bad_keep
        $error("pcie_us_axis_rc_cpl_parse: AXIS_PCIE_KEEP_WIDTH*32 must equal AXIS_PCIE_DATA_WIDTH");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_FLUSH} state_t;

    state_t          state_q, state_d;

    logic            room_q, room_d;
    logic            hdr_vld_q, hdr_vld_d;
    logic [87:0]     hdr_q, hdr_d;
    logic            stat_q, stat_d;
    logic [RDW-1:0]  res_dat_q, res_dat_d;
    logic [RKW-1:0]  res_keep_q, res_keep_d;

    logic            out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [DW-1:0]   out_dat_q, out_dat_d;
    logic [KW-1:0]   out_keep_q, out_keep_d;
    logic            tmp_vld_q, tmp_vld_d, tmp_last_q, tmp_last_d;
    logic [DW-1:0]   tmp_dat_q, tmp_dat_d;
    logic [KW-1:0]   tmp_keep_q, tmp_keep_d;

    logic            in_rdy, in_acc;
    logic            hdr_load, res_load;
    logic            push, push_last;
    logic [DW-1:0]   push_dat;
    logic [KW-1:0]   push_keep;
    logic            body_spill;

    // Header-register stall only gates descriptor beats; FLUSH never takes input.
    assign in_rdy = room_q && ((state_q == ST_BODY) ||
                               (state_q == ST_IDLE && (!hdr_vld_q || m_axis_hdr_ready)));
    assign in_acc = s_axis_rc_tvalid && in_rdy;

    // tkeep is contiguous, so "more than 3 dwords" reduces to tkeep[3].
    assign body_spill = s_axis_rc_tkeep[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_acc && !s_axis_rc_tlast) begin
                    state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                if (in_acc && s_axis_rc_tlast) begin
                    state_d = body_spill ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (room_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hdr_load  = 1'b0;
        res_load  = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        push_dat  = '0;
        push_keep = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_acc) begin
                    hdr_load = 1'b1;
                    if (s_axis_rc_tlast) begin
                        push      = body_spill;
                        push_last = 1'b1;
                        push_dat  = {96'b0, s_axis_rc_tdata[DW-1:96]};
                        push_keep = {3'b0, s_axis_rc_tkeep[KW-1:3]};
                    end else begin
                        res_load = 1'b1;
                    end
                end
            end
            ST_BODY: begin
                if (in_acc) begin
                    push      = 1'b1;
                    push_last = s_axis_rc_tlast && !body_spill;
                    push_dat  = {s_axis_rc_tdata[95:0], res_dat_q};
                    push_keep = {s_axis_rc_tkeep[2:0], res_keep_q};
                    res_load  = !s_axis_rc_tlast || body_spill;
                end
            end
            ST_FLUSH: begin
                if (room_q) begin
                    push      = 1'b1;
                    push_last = 1'b1;
                    push_dat  = {96'b0, res_dat_q};
                    push_keep = {3'b0, res_keep_q};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        hdr_d      = hdr_q;
        hdr_vld_d  = hdr_vld_q;
        res_dat_d  = res_dat_q;
        res_keep_d = res_keep_q;
        stat_d     = 1'b0;
        if (hdr_load) begin
            hdr_d     = s_axis_rc_tdata[87:0];
            hdr_vld_d = 1'b1;
            stat_d    = (|s_axis_rc_tdata[15:12]) || (|s_axis_rc_tdata[45:43]) || s_axis_rc_tdata[46];
        end else if (m_axis_hdr_ready) begin
            hdr_vld_d = 1'b0;
        end
        if (res_load) begin
            res_dat_d  = s_axis_rc_tdata[DW-1:96];
            res_keep_d = s_axis_rc_tkeep[KW-1:3];
        end
    end

    // Skid: room_q promises space for one push next cycle, so input ready stays registered.
    always_comb begin
        room_d     = m_axis_data_tready || (!tmp_vld_q && (!out_vld_q || !push));
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        out_dat_d  = out_dat_q;
        out_keep_d = out_keep_q;
        tmp_vld_d  = tmp_vld_q;
        tmp_last_d = tmp_last_q;
        tmp_dat_d  = tmp_dat_q;
        tmp_keep_d = tmp_keep_q;
        if (room_q) begin
            if (m_axis_data_tready || !out_vld_q) begin
                out_vld_d  = push;
                out_last_d = push_last;
                out_dat_d  = push_dat;
                out_keep_d = push_keep;
            end else begin
                tmp_vld_d  = push;
                tmp_last_d = push_last;
                tmp_dat_d  = push_dat;
                tmp_keep_d = push_keep;
            end
        end else if (m_axis_data_tready) begin
            out_vld_d  = tmp_vld_q;
            out_last_d = tmp_last_q;
            out_dat_d  = tmp_dat_q;
            out_keep_d = tmp_keep_q;
            tmp_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            room_q     <= 1'b0;
            hdr_vld_q  <= 1'b0;
            hdr_q      <= '0;
            stat_q     <= 1'b0;
            res_dat_q  <= '0;
            res_keep_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_dat_q  <= '0;
            out_keep_q <= '0;
            tmp_vld_q  <= 1'b0;
            tmp_last_q <= 1'b0;
            tmp_dat_q  <= '0;
            tmp_keep_q <= '0;
        end else begin
            room_q     <= room_d;
            hdr_vld_q  <= hdr_vld_d;
            hdr_q      <= hdr_d;
            stat_q     <= stat_d;
            res_dat_q  <= res_dat_d;
            res_keep_q <= res_keep_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            out_dat_q  <= out_dat_d;
            out_keep_q <= out_keep_d;
            tmp_vld_q  <= tmp_vld_d;
            tmp_last_q <= tmp_last_d;
            tmp_dat_q  <= tmp_dat_d;
            tmp_keep_q <= tmp_keep_d;
        end
    end

    assign s_axis_rc_tready             = in_rdy;

    assign m_axis_hdr_valid             = hdr_vld_q;
    assign m_axis_hdr_lower_addr        = hdr_q[11:0];
    assign m_axis_hdr_error_code        = hdr_q[15:12];
    assign m_axis_hdr_byte_count        = hdr_q[28:16];
    assign m_axis_hdr_request_completed = hdr_q[30];
    assign m_axis_hdr_dword_count       = hdr_q[42:32];
    assign m_axis_hdr_status            = hdr_q[45:43];
    assign m_axis_hdr_poisoned          = hdr_q[46];
    assign m_axis_hdr_requester_id      = hdr_q[63:48];
    assign m_axis_hdr_tag               = hdr_q[71:64];
    assign m_axis_hdr_completer_id      = hdr_q[87:72];

    assign m_axis_data_tdata            = out_dat_q;
    assign m_axis_data_tkeep            = out_keep_q;
    assign m_axis_data_tvalid           = out_vld_q;
    assign m_axis_data_tlast            = out_last_q;

    assign stat_error                   = stat_q;

    logic unused_ok;
    assign unused_ok = ^{s_axis_rc_tuser, hdr_q[29], hdr_q[31], hdr_q[47]};

endmodule
